// File: rtl/uart_cpu_pkg.sv
// Shared definitions for the UART-to-CPU interrupt controller: byte width,
// default sizing and the request handshake state encoding.
package uart_cpu_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo
    import uart_cpu_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = BYTE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against occupancy; pop frees a slot for a same-edge push.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    assign full  = (count_r == CNT_MAX);
    assign empty = (count_r == {(AW + 1){1'b0}});
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_irq_ctrl.sv
// Buffers UART bytes and offers them to the CPU one at a time through an
// int0 request / cpu_end_read acknowledge handshake with timeout.
module uart_irq_ctrl
    import uart_cpu_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    input  logic                    cpu_end_read,
    output logic [7:0]              uart_to_cpu,
    output logic                    int0,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overrun,
    output logic                    timeout,
    input  logic                    flags_clr
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    irq_state_e    state_r;
    irq_state_e    state_nxt_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic          int0_nxt_s;
    logic [7:0]    data_nxt_s;
    logic          pop_s;
    logic          tmo_hit_s;
    logic          overrun_set_s;
    logic [7:0]    fifo_dout_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .din   (rx_byte),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    // An acknowledge in the same cycle as the last timer tick takes priority.
    assign tmo_hit_s     = (state_r == REQ) && !cpu_end_read && (timer_r == TMR_LAST);
    assign overrun_set_s = rx_valid && fifo_full_s && !pop_s;

    // State, handshake outputs and sticky flags register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            timer_r     <= {TW{1'b0}};
            int0        <= 1'b0;
            uart_to_cpu <= 8'h00;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            timer_r     <= timer_nxt_s;
            int0        <= int0_nxt_s;
            uart_to_cpu <= data_nxt_s;
            overrun     <= overrun_set_s ? 1'b1 : (flags_clr ? 1'b0 : overrun);
            timeout     <= tmo_hit_s     ? 1'b1 : (flags_clr ? 1'b0 : timeout);
        end
    end

    // Next-state: RELEASE waits for the level acknowledge to drop so one ack covers one byte.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) state_nxt_s = REQ;
                else               state_nxt_s = IDLE;
            end
            REQ: begin
                if (cpu_end_read || tmo_hit_s) state_nxt_s = RELEASE;
                else                           state_nxt_s = REQ;
            end
            RELEASE: begin
                if (!cpu_end_read) state_nxt_s = IDLE;
                else               state_nxt_s = RELEASE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Outputs: the offered byte is loaded only on IDLE->REQ and held otherwise.
    always_comb begin
        pop_s       = 1'b0;
        int0_nxt_s  = 1'b0;
        data_nxt_s  = uart_to_cpu;
        timer_nxt_s = timer_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    int0_nxt_s  = 1'b1;
                    data_nxt_s  = fifo_dout_s;
                    timer_nxt_s = {TW{1'b0}};
                end else begin
                    int0_nxt_s  = 1'b0;
                end
            end
            REQ: begin
                if (cpu_end_read || tmo_hit_s) begin
                    int0_nxt_s  = 1'b0;
                end else begin
                    int0_nxt_s  = 1'b1;
                    timer_nxt_s = timer_r + TMR_ONE;
                end
            end
            RELEASE: int0_nxt_s = 1'b0;
            default: int0_nxt_s = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Self-checking bench for uart_irq_ctrl: a scoreboard queue holds the bytes the
// CPU must see; a monitor pops and compares on every int0 rising edge.
module tb_uart_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       cpu_end_read = 1'b0;
    logic       flags_clr = 1'b0;
    logic [7:0] uart_to_cpu;
    logic       int0;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       timeout;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    uart_irq_ctrl #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .cpu_end_read (cpu_end_read),
        .uart_to_cpu  (uart_to_cpu),
        .int0         (int0),
        .fifo_count   (fifo_count),
        .overrun      (overrun),
        .timeout      (timeout),
        .flags_clr    (flags_clr)
    );

    always #5 clk = ~clk;

    // Monitor: each new request must carry the next expected byte, held stable.
    logic       int0_prev = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp_b;
    always @(negedge clk) begin
        if (rst) begin
            int0_prev = 1'b0;
        end else begin
            if (int0 === 1'b1 && int0_prev !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_int0 got byte %02h, required no request", uart_to_cpu);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (uart_to_cpu !== exp_b) begin
                        failures++;
                        $display("FAIL delivered_byte got %02h, required %02h", uart_to_cpu, exp_b);
                    end
                end
                held = uart_to_cpu;
            end else if (int0 === 1'b1) begin
                checks++;
                if (uart_to_cpu !== held) begin
                    failures++;
                    $display("FAIL data_stable got %02h, required %02h", uart_to_cpu, held);
                end
            end
            int0_prev = int0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        cpu_end_read = 1'b0;
        flags_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n, input int n_exp);
        for (int i = 0; i < n; i++) begin
            rx_byte = first + 8'(i);
            rx_valid = 1'b1;
            if (i < n_exp) exp_q.push_back(first + 8'(i));
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic cpu_ack(input int dly);
        int n;
        n = 0;
        while (int0 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (int0 !== 1'b1) begin
            checks++; failures++;
            $display("FAIL ack_wait_req got int0=%b, required 1", int0);
            return;
        end
        repeat (dly) @(negedge clk);
        cpu_end_read = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (int0 === 1'b1 && n < 40);
        cpu_end_read = 1'b0;
        checks++;
        if (int0 !== 1'b0) begin
            failures++;
            $display("FAIL ack_drop got int0=%b, required 0", int0);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL %s_drained got pending=%0d count=%0d, required 0 0", name, exp_q.size(), fifo_count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({int0, uart_to_cpu, fifo_count, overrun, timeout} !== 13'd0) begin
            failures++;
            $display("FAIL reset_state got int0=%b data=%02h cnt=%0d ovr=%b tmo=%b, required all 0",
                     int0, uart_to_cpu, fifo_count, overrun, timeout);
        end
    endtask

    task automatic test_single();
        logic       e_int0;
        logic [2:0] e_cnt;
        do_reset();
        for (int t = 0; t < 13; t++) begin
            case (t)
                0: begin rx_byte = 8'hA5; rx_valid = 1'b1; exp_q.push_back(8'hA5); end
                1: rx_valid = 1'b0;
                5: cpu_end_read = 1'b1;
                8: cpu_end_read = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            e_int0 = (t >= 1 && t <= 4);
            e_cnt  = (t == 0) ? 3'd1 : 3'd0;
            checks++;
            if (int0 !== e_int0 || fifo_count !== e_cnt) begin
                failures++;
                $display("FAIL single_t%0d got int0=%b cnt=%0d, required int0=%b cnt=%0d",
                         t, int0, fifo_count, e_int0, e_cnt);
            end
        end
        checks++;
        if (uart_to_cpu !== 8'hA5) begin
            failures++;
            $display("FAIL single_hold got %02h, required a5", uart_to_cpu);
        end
        check_drained("single");
    endtask

    task automatic test_burst();
        do_reset();
        push_bytes(8'h01, 4, 4);
        for (int i = 0; i < 4; i++) cpu_ack(5);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL burst_overrun got %b, required 0", overrun);
        end
        check_drained("burst");
    endtask

    task automatic test_overrun();
        do_reset();
        push_bytes(8'h10, 6, 5);
        checks++;
        if (fifo_count !== 3'd4 || overrun !== 1'b1 || uart_to_cpu !== 8'h10 || int0 !== 1'b1) begin
            failures++;
            $display("FAIL overrun_full got cnt=%0d ovr=%b data=%02h int0=%b, required 4 1 10 1",
                     fifo_count, overrun, uart_to_cpu, int0);
        end
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear got %b, required 0", overrun);
        end
        for (int i = 0; i < 5; i++) cpu_ack(0);
        check_drained("overrun");
    endtask

    task automatic test_full_pop();
        do_reset();
        push_bytes(8'h20, 5, 5);
        cpu_end_read = 1'b1;
        @(negedge clk);
        cpu_end_read = 1'b0;
        @(negedge clk);
        rx_byte = 8'h77;
        rx_valid = 1'b1;
        exp_q.push_back(8'h77);
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || overrun !== 1'b0 || int0 !== 1'b1 || uart_to_cpu !== 8'h21) begin
            failures++;
            $display("FAIL full_pop got cnt=%0d ovr=%b int0=%b data=%02h, required 4 0 1 21",
                     fifo_count, overrun, int0, uart_to_cpu);
        end
        for (int i = 0; i < 5; i++) cpu_ack(0);
        check_drained("full_pop");
    endtask

    task automatic test_timeout();
        int n;
        int hi;
        int lo;
        do_reset();
        push_bytes(8'h3C, 2, 2);
        n = 0;
        while (int0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pre got %b, required 0", timeout);
        end
        hi = 0;
        while (int0 === 1'b1 && hi < 40) begin hi++; @(negedge clk); end
        checks++;
        if (hi != 8 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_len got high=%0d tmo=%b, required 8 1", hi, timeout);
        end
        lo = 0;
        while (int0 !== 1'b1 && lo < 40) begin lo++; @(negedge clk); end
        checks++;
        if (lo != 2) begin
            failures++;
            $display("FAIL timeout_gap got %0d, required 2", lo);
        end
        cpu_ack(0);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear got %b, required 0", timeout);
        end
        check_drained("timeout");
    endtask

    task automatic test_ack_level();
        int lo;
        do_reset();
        push_bytes(8'h5A, 2, 2);
        cpu_end_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (int0 !== 1'b0 || fifo_count !== 3'd1) begin
                failures++;
                $display("FAIL ack_level_hold%0d got int0=%b cnt=%0d, required 0 1", i, int0, fifo_count);
            end
        end
        cpu_end_read = 1'b0;
        lo = 0;
        while (int0 !== 1'b1 && lo < 40) begin @(negedge clk); lo++; end
        checks++;
        if (lo != 2) begin
            failures++;
            $display("FAIL ack_level_gap got %0d, required 2", lo);
        end
        cpu_ack(0);
        check_drained("ack_level");
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_bytes(8'h31, 4, 1);
        checks++;
        if (fifo_count !== 3'd3 || int0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre got cnt=%0d int0=%b, required 3 1", fifo_count, int0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (int0 !== 1'b0 || fifo_count !== 3'd0 || uart_to_cpu !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid got int0=%b cnt=%0d data=%02h, required 0 0 00",
                     int0, fifo_count, uart_to_cpu);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (int0 !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_quiet%0d got int0=%b, required 0", i, int0);
            end
        end
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overrun();
        test_full_pop();
        test_timeout();
        test_ack_level();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_irq_ctrl.md
Name: uart_irq_ctrl

Overview:
- Sits between the UART receiver and the MIPS CPU interrupt input int0.
- Buffers received bytes in a small FIFO and presents one byte at a time on a stable data register.
- Sequences the int0 request / cpu_end_read acknowledge handshake per byte, with a timeout and overrun reporting.
- Replaces the direct UART-to-CPU interrupt wiring, so that no byte is lost while the CPU is still servicing the previous one.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- TIMEOUT, 1024: cycles in REQ without acknowledge before the request is abandoned; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_byte  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- cpu_end_read  in  1  CPU acknowledge (level); high = byte consumed
- uart_to_cpu  out  8  byte currently offered to CPU (registered)
- int0  out  1  interrupt request to CPU (registered)
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- overrun  out  1  sticky: byte dropped because FIFO full
- timeout  out  1  sticky: request abandoned without acknowledge
- flags_clr  in  1  clears overrun and timeout

Behaviour:
- Reset (clk edge with rst=1): FIFO empty, fifo_count=0, uart_to_cpu=8'h00, int0=0, overrun=0, timeout=0, FSM=IDLE, timer=0. Reset mid-handshake drops int0 on the next edge and discards all buffered bytes.
- Push: rx_valid=1 and not full -> write rx_byte at tail; count+1 next cycle.
- Push when full: byte dropped; overrun=1 next cycle.
- Push and pop on the same edge: always accepted, including when full; count unchanged.
- Pointers wrap modulo DEPTH.
- FSM IDLE:
  - If count>0: uart_to_cpu<=head, pop, int0<=1, timer<=0 -> REQ.
  - Latency: rx_valid at cycle N into an empty FIFO -> count=1 at N+1 -> int0=1 and uart_to_cpu valid at N+2. No bypass path.
- FSM REQ: int0 held at 1; uart_to_cpu held stable.
  - cpu_end_read=1 -> int0<=0 -> RELEASE.
  - Else if timer==TIMEOUT-1 -> int0<=0, timeout<=1 -> RELEASE.
  - Otherwise timer+1.
- FSM RELEASE: int0=0; wait for cpu_end_read=0, then -> IDLE.
  - A level acknowledge held high therefore acks exactly one byte.
  - Minimum gap between consecutive int0 pulses: 2 cycles (RELEASE, IDLE).
- uart_to_cpu keeps its last value outside REQ. It changes only on the IDLE->REQ transition.
- flags_clr=1: clears both sticky flags. If a set event occurs in the same cycle, set wins.
- cpu_end_read=1 in IDLE is ignored.
- fifo_count excludes the byte already moved into uart_to_cpu.

Decomposition:
- Shared package uart_cpu_pkg:
  - FSM state enum (IDLE, REQ, RELEASE).
  - Byte width constant 8.
  - Default DEPTH and TIMEOUT.
- One sub-module, sync_fifo:
  - Ports: clk, rst, push, din, pop, dout, full, empty, count.
  - Parameterized by DEPTH and width.
- FSM, timer and sticky flags stay in uart_irq_ctrl.

Test Plan:
- Reset, then single byte: rx_byte=8'hA5 strobe at cycle 10 -> int0=1 and uart_to_cpu=8'hA5 at cycle 12; cpu_end_read high at 15 -> int0=0 at 16; cpu_end_read low at 18 -> FSM returns to IDLE; fifo_count=0 throughout after cycle 12.
- Burst: push 8'h01..8'h04 on back-to-back cycles, CPU acks each after 5 cycles -> CPU sees 01,02,03,04 in order; overrun stays 0.
- Overrun: hold cpu_end_read=0, push 6 bytes (DEPTH=4) -> first byte in uart_to_cpu, 4 in FIFO, 6th dropped; overrun=1; flags_clr pulse -> overrun=0.
- Full with simultaneous pop: FIFO full, ack completes so IDLE pops on the same edge as a push of 8'h77 -> count stays 4; 8'h77 delivered last.
- Timeout (TIMEOUT=8): byte pending, no ack -> int0 falls after 8 cycles in REQ; timeout=1; next byte requested 2 cycles later.
- Reset mid-REQ with 3 bytes buffered -> next cycle int0=0, fifo_count=0, uart_to_cpu=8'h00; no further int0 without new rx_valid.
